// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding and PC-mux select constants for the fetch controller
package fetch_pkg;
    typedef enum logic [1:0] {IDLE, FETCH, HOLD, FAULT} fetch_state_t;
    localparam logic PCSRC_INC    = 1'b0;
    localparam logic PCSRC_BRANCH = 1'b1;
endpackage

// File: rtl/fetch_wait_timer.sv
// fetch_wait_timer: counts cycles spent waiting for imem_ack and flags the last allowed cycle
module fetch_wait_timer #(
    parameter int WAIT_MAX = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int W = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;
    localparam logic [W-1:0] LAST = W'((WAIT_MAX > 0) ? WAIT_MAX - 1 : 0);
    logic [W-1:0] cnt_q, cnt_d;
    // restart on every FETCH entry, count each waiting cycle
    always_comb cnt_d = clear ? '0 : (enable ? cnt_q + 1'b1 : cnt_q);
    // wait counter register
    always_ff @(posedge clk or negedge rst)
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    assign expired = (WAIT_MAX > 0) && enable && !clear && (cnt_q == LAST);
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: sequences PC updates against a variable-latency imem and the decode handshake
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int WAIT_MAX = 16,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req,
    input  logic             imem_ack,
    output logic             instr_valid,
    input  logic             dec_ready,
    input  logic             branch_take,
    output logic             branch_ack,
    output logic             pc_en,
    output logic             pc_src,
    output logic             fetch_fault,
    output logic [CNT_W-1:0] fetch_count
);
    fetch_state_t     state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             expired;

    fetch_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (state_q != FETCH),
        .enable  (state_q == FETCH),
        .expired (expired)
    );

    // next state, Moore outputs from state, Mealy PC controls on decode acceptance
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        branch_ack  = 1'b0;
        pc_en       = 1'b0;
        pc_src      = PCSRC_INC;
        fetch_fault = 1'b0;
        case (state_q)
            IDLE:  state_d = FETCH;
            FETCH: begin
                imem_req = 1'b1;
                state_d  = imem_ack ? HOLD : (expired ? FAULT : FETCH);
            end
            HOLD: begin
                instr_valid = 1'b1;
                if (dec_ready) begin
                    pc_en      = 1'b1;
                    pc_src     = branch_take ? PCSRC_BRANCH : PCSRC_INC;
                    branch_ack = branch_take;
                    count_d    = count_q + 1'b1;
                    state_d    = FETCH;
                end
            end
            default: fetch_fault = 1'b1;
        endcase
    end

    // state and retired-fetch counter registers
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state_q <= IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end

    assign fetch_count = count_q;
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: randomized transaction-level check of fetch_ctrl with a bench-side PC register
module tb_fetch_ctrl;
    localparam int WAIT_MAX = 4;
    localparam int CNT_W    = 4;
    localparam logic [31:0] BASE = 32'h0000_1000;

    logic clk = 1'b0;
    logic rst, imem_ack, dec_ready, branch_take;
    logic imem_req, instr_valid, branch_ack, pc_en, pc_src, fetch_fault;
    logic [CNT_W-1:0] fetch_count;
    logic [31:0] pc, imm, exp_pc;
    int exp_count, checks, errors;

    fetch_ctrl #(.WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_ack    (imem_ack),
        .instr_valid (instr_valid),
        .dec_ready   (dec_ready),
        .branch_take (branch_take),
        .branch_ack  (branch_ack),
        .pc_en       (pc_en),
        .pc_src      (pc_src),
        .fetch_fault (fetch_fault),
        .fetch_count (fetch_count)
    );

    always #5 clk = ~clk;

    // PC datapath driven by the controller: PC+4 or PC+ImmOp
    always_ff @(posedge clk or negedge rst)
        if (!rst)       pc <= BASE;
        else if (pc_en) pc <= pc_src ? pc + imm : pc + 32'd4;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [31:0] outs();
        return 32'({imem_req, instr_valid, pc_en, pc_src, branch_ack, fetch_fault});
    endfunction

    // reset asserted mid-cycle with a stray ack; one idle cycle after release, then fetching
    task automatic do_reset();
        rst = 1'b0; imem_ack = 1'b1; dec_ready = 1'b1; branch_take = 1'b1;
        #1;
        check("rst_outs", outs(), 32'h0);
        check("rst_count", 32'(fetch_count), 32'h0);
        exp_count = 0;
        exp_pc = BASE;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check("idle_outs", outs(), 32'h0);
        step();
        imem_ack = 1'b0;
    endtask

    // one PC's worth: wait ack_dly cycles for imem, hold rdy_dly cycles for decode
    task automatic txn(input int ack_dly, input int rdy_dly, input bit br, input bit br_early, input bit abort);
        bit last;
        imm = $urandom & 32'h0000_FFFC;
        for (int i = 0; i < WAIT_MAX && i <= ack_dly; i++) begin
            imem_ack = (i == ack_dly); dec_ready = 1'($urandom); branch_take = br & br_early;
            #1;
            check("fetch_outs", outs(), 32'b100000);
            if (abort && i == 1) begin
                do_reset();
                return;
            end
            step();
        end
        if (ack_dly >= WAIT_MAX) begin
            for (int k = 0; k < 3; k++) begin
                imem_ack = 1'(k != 1); dec_ready = 1'b1; branch_take = br;
                #1;
                check("fault_outs", outs(), 32'b000001);
                step();
            end
            do_reset();
            return;
        end
        for (int j = 0; j <= rdy_dly; j++) begin
            last = (j == rdy_dly);
            dec_ready = last; branch_take = br; imem_ack = 1'($urandom);
            #1;
            check("hold_outs", outs(), 32'({1'b0, 1'b1, last, last & br, last & br, 1'b0}));
            step();
        end
        exp_count++;
        exp_pc = exp_pc + (br ? imm : 32'd4);
        branch_take = 1'b0; imem_ack = 1'b0;
        #1;
        check("count", 32'(fetch_count), 32'(exp_count & 15));
        check("pc", pc, exp_pc);
    endtask

    initial begin
        checks = 0; errors = 0;
        rst = 1'b0; imem_ack = 1'b0; dec_ready = 1'b0; branch_take = 1'b0; imm = '0;
        do_reset();
        txn(0, 0, 1'b0, 1'b0, 1'b0);
        txn(0, 5, 1'b1, 1'b0, 1'b0);
        txn(3, 0, 1'b1, 1'b1, 1'b0);
        txn(4, 0, 1'b0, 1'b0, 1'b0);
        txn(3, 1, 1'b0, 1'b0, 1'b0);
        txn(3, 0, 1'b0, 1'b0, 1'b1);
        for (int n = 0; n < 17; n++)
            txn($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), 1'($urandom), 1'b0);
        check("wrap", 32'(fetch_count), 32'h1);
        for (int n = 0; n < 120; n++)
            txn($urandom_range(0, 5), $urandom_range(0, 4), 1'($urandom), 1'($urandom),
                $urandom_range(0, 15) == 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
